// File: rtl/freq_meter_ctrl.sv
// -----------------------------------------------------------------------------
// freq_meter_ctrl
//
// Purpose
//    Measurement sequencer for the frequency-meter datapath. The datapath is a
//    decade counter chain, then display load registers, then 7-segment
//    decoders. Each measurement runs the same fixed sequence:
//       1. Hold the counter clear low.
//       2. Open a gate window of fixed length. During the window the
//          synchronized input signal is passed to the counter chain.
//       3. Pulse the display-register load for one cycle.
//       4. Pulse done for one cycle.
//    The block runs either a single measurement or repeats continuously. It
//    also captures whether the most-significant decade overflowed during
//    the window.
//
// Parameters
//    GATE_CYCLES : clk cycles the gate stays open (>= 2)
//    CLR_CYCLES  : clk cycles cnt_clr_n is held low before the gate (>= 1)
//
// Ports
//    clk        in   system clock, rising edge
//    reset      in   asynchronous active-low reset, clears all state
//    start      in   level, sampled in IDLE, begins a measurement
//    cont       in   level, 1 = restart at CLEAR after DONE without start
//    stop       in   synchronous abort back to IDLE
//    sig_in     in   asynchronous signal under measurement
//    ovf_in     in   carry-out of the most-significant decade counter
//    gated_sig  out  carry-in of the least-significant decade
//    cnt_clr_n  out  active-low clear to the decade counters
//    load       out  load enable to the display registers
//    gate       out  1 while the gate window is open
//    busy       out  1 in every state except IDLE
//    done       out  one-cycle pulse after load
//    overflow   out  1 = last completed measurement overflowed
// -----------------------------------------------------------------------------
module freq_meter_ctrl #(
   parameter int GATE_CYCLES = 1000,
   parameter int CLR_CYCLES  = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic start,
   input  logic cont,
   input  logic stop,
   input  logic sig_in,
   input  logic ovf_in,
   output logic gated_sig,
   output logic cnt_clr_n,
   output logic load,
   output logic gate,
   output logic busy,
   output logic done,
   output logic overflow
);

   // One timer serves both CLEAR and GATE. It is sized for whichever
   // phase is longer.
   localparam int TW = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
   localparam int CW = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;
   localparam int W  = (TW > CW) ? TW : CW;

   localparam logic [W-1:0] GATE_LAST = W'(GATE_CYCLES - 1);
   localparam logic [W-1:0] CLR_LAST  = W'(CLR_CYCLES - 1);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_CLEAR = 3'd1,
      ST_GATE  = 3'd2,
      ST_LATCH = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

   state_t         state_reg;
   logic [W-1:0]   timer_reg;
   logic           ovf_pend_reg;
   logic           ovf_d_reg;

   logic           gated_sig_reg;
   logic           cnt_clr_n_reg;
   logic           load_reg;
   logic           gate_reg;
   logic           busy_reg;
   logic           done_reg;
   logic           overflow_reg;

   // -------------------------------------------------------------------------
   // Two-flop synchronizers for both asynchronous inputs.
   // Bit 0 carries sig_in and bit 1 carries ovf_in.
   // -------------------------------------------------------------------------
   logic [1:0] async_in;
   logic [1:0] sync_out;

   assign async_in = {ovf_in, sig_in};

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_sync
         logic s1_reg;
         logic s2_reg;

         always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
               s1_reg <= 1'b0;
               s2_reg <= 1'b0;
            end else begin
               s1_reg <= async_in[gi];
               s2_reg <= s1_reg;
            end
         end

         assign sync_out[gi] = s2_reg;
      end
   endgenerate

   logic sig_s2;
   logic ovf_s2;
   logic ovf_rise;

   assign sig_s2   = sync_out[0];
   assign ovf_s2   = sync_out[1];
   // The decade carry is a level that may stay high for many cycles.
   // Only a fresh 0->1 transition means the chain wrapped.
   assign ovf_rise = ovf_s2 & ~ovf_d_reg;

   // -------------------------------------------------------------------------
   // Sequencer. Every output is a register. Each output is updated on the
   // edge that enters the state driving it, so the outputs line up exactly
   // with the state boundaries.
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg     <= ST_IDLE;
         timer_reg     <= '0;
         ovf_pend_reg  <= 1'b0;
         ovf_d_reg     <= 1'b0;
         gated_sig_reg <= 1'b0;
         cnt_clr_n_reg <= 1'b1;
         load_reg      <= 1'b0;
         gate_reg      <= 1'b0;
         busy_reg      <= 1'b0;
         done_reg      <= 1'b0;
         overflow_reg  <= 1'b0;
      end else begin
         ovf_d_reg <= ovf_s2;

         if (stop) begin
            // Abort: drop everything except the last completed result.
            // No load and no done are issued for the aborted measurement.
            state_reg     <= ST_IDLE;
            timer_reg     <= '0;
            gated_sig_reg <= 1'b0;
            cnt_clr_n_reg <= 1'b1;
            load_reg      <= 1'b0;
            gate_reg      <= 1'b0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
         end else begin
            case (state_reg)
               ST_IDLE: begin
                  if (start) begin
                     state_reg     <= ST_CLEAR;
                     timer_reg     <= '0;
                     cnt_clr_n_reg <= 1'b0;
                     busy_reg      <= 1'b1;
                  end
               end

               ST_CLEAR: begin
                  // A carry seen while the counters are being cleared is
                  // stale. It must not count against this measurement.
                  ovf_pend_reg <= 1'b0;
                  if (timer_reg == CLR_LAST) begin
                     state_reg     <= ST_GATE;
                     timer_reg     <= '0;
                     cnt_clr_n_reg <= 1'b1;
                     gate_reg      <= 1'b1;
                     gated_sig_reg <= sig_s2;
                  end else begin
                     timer_reg <= timer_reg + W'(1);
                  end
               end

               ST_GATE: begin
                  if (ovf_rise) begin
                     ovf_pend_reg <= 1'b1;
                  end
                  if (timer_reg == GATE_LAST) begin
                     state_reg     <= ST_LATCH;
                     gate_reg      <= 1'b0;
                     // gated_sig falls here if sig was high. The counter
                     // sees that as one more edge. This gives the usual
                     // +/-1 count quantization of a gated counter.
                     gated_sig_reg <= 1'b0;
                     load_reg      <= 1'b1;
                     // A rise on the final gate cycle still belongs to
                     // this window. Fold it in directly, because
                     // ovf_pend_reg only updates on this same edge.
                     overflow_reg  <= ovf_pend_reg | ovf_rise;
                  end else begin
                     timer_reg     <= timer_reg + W'(1);
                     gated_sig_reg <= sig_s2;
                  end
               end

               ST_LATCH: begin
                  // load is high for one full clk period. Display
                  // registers that capture on the falling edge therefore
                  // sample exactly once.
                  state_reg <= ST_DONE;
                  load_reg  <= 1'b0;
                  done_reg  <= 1'b1;
               end

               ST_DONE: begin
                  done_reg <= 1'b0;
                  if (cont) begin
                     state_reg     <= ST_CLEAR;
                     timer_reg     <= '0;
                     cnt_clr_n_reg <= 1'b0;
                  end else begin
                     state_reg <= ST_IDLE;
                     busy_reg  <= 1'b0;
                  end
               end

               default: begin
                  state_reg     <= ST_IDLE;
                  timer_reg     <= '0;
                  gated_sig_reg <= 1'b0;
                  cnt_clr_n_reg <= 1'b1;
                  load_reg      <= 1'b0;
                  gate_reg      <= 1'b0;
                  busy_reg      <= 1'b0;
                  done_reg      <= 1'b0;
               end
            endcase
         end
      end
   end

   assign gated_sig = gated_sig_reg;
   assign cnt_clr_n = cnt_clr_n_reg;
   assign load      = load_reg;
   assign gate      = gate_reg;
   assign busy      = busy_reg;
   assign done      = done_reg;
   assign overflow  = overflow_reg;

endmodule

// File: tb/tb_freq_meter_ctrl.sv
// -----------------------------------------------------------------------------
// tb_freq_meter_ctrl
//
// Bench for freq_meter_ctrl with GATE_CYCLES=40 and CLR_CYCLES=2.
//
// A monitor watches the outputs on every falling clk edge. For each
// completed measurement it builds one record and pushes it when done
// pulses. The records hold:
//    - phase lengths,
//    - gated_sig falling edges inside and outside the window,
//    - the overflow value at load and at done,
//    - the cycle stamp of the load.
// Each scenario task pushes its expected results when it drives start. It
// pops and compares them once the matching record has arrived.
// -----------------------------------------------------------------------------
module tb_freq_meter_ctrl;

   localparam int GC   = 40;
   localparam int CC   = 2;
   localparam int MEAS = GC + CC + 2;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic start = 1'b0;
   logic cont = 1'b0;
   logic stop = 1'b0;
   logic sig_in = 1'b0;
   logic ovf_in = 1'b0;
   logic gated_sig, cnt_clr_n, load, gate, busy, done, overflow;

   int total = 0;
   int bad = 0;

   freq_meter_ctrl #(
      .GATE_CYCLES(GC),
      .CLR_CYCLES (CC)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .cont     (cont),
      .stop     (stop),
      .sig_in   (sig_in),
      .ovf_in   (ovf_in),
      .gated_sig(gated_sig),
      .cnt_clr_n(cnt_clr_n),
      .load     (load),
      .gate     (gate),
      .busy     (busy),
      .done     (done),
      .overflow (overflow)
   );

   always #5 clk = ~clk;

   // Input signal: period 4 clk (40 ns), 50% duty, phase offset from clk.
   initial begin
      #3;
      forever #20 sig_in = ~sig_in;
   end

   typedef struct {
      int   clr_c;
      int   gate_c;
      int   load_c;
      int   busy_c;
      int   falls;
      int   leak;
      logic ovf_load;
      logic ovf_done;
      int   load_cyc;
   } meas_t;

   typedef struct {
      logic ovf;
      int   fmin;
      int   fmax;
   } exp_t;

   meas_t obs_q[$];
   exp_t  exp_q[$];

   int    cyc = 0;
   int    load_total = 0;
   int    done_total = 0;
   int    excl_err = 0;
   meas_t cur;
   logic  p_clr_n = 1'b1;
   logic  p_gs = 1'b0;
   logic  p_gate = 1'b0;

   // Output monitor: samples on the falling edge.
   initial begin
      cur = '{default: 0};
      forever begin
         @(negedge clk);
         cyc++;
         if (reset) begin
            if (p_clr_n && !cnt_clr_n) begin
               // Start of a new measurement; this cycle is its first.
               cur        = '{default: 0};
               cur.clr_c  = 1;
               cur.busy_c = 1;
            end else begin
               cur.clr_c  += int'(!cnt_clr_n);
               cur.gate_c += int'(gate);
               cur.load_c += int'(load);
               cur.busy_c += int'(busy);
            end
            if (p_gs && !gated_sig) begin
               if (p_gate) cur.falls++;
               else        cur.leak++;
            end
            if (gated_sig && !gate) cur.leak++;
            if (int'(!cnt_clr_n) + int'(gate) + int'(load) > 1) excl_err++;
            if (load) begin
               load_total++;
               cur.ovf_load = overflow;
               cur.load_cyc = cyc;
            end
            if (done) begin
               done_total++;
               cur.ovf_done = overflow;
               obs_q.push_back(cur);
            end
         end
         p_clr_n = cnt_clr_n;
         p_gs    = gated_sig;
         p_gate  = gate;
      end
   end

   task automatic pulse_start();
      @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   task automatic wait_obs(input int n, input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         if (obs_q.size() >= n) begin
            ok = 1'b1;
            break;
         end
         @(posedge clk);
      end
      if (obs_q.size() >= n) ok = 1'b1;
   endtask

   task automatic wait_gate(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (gate === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      #2 reset = 1'b0;
      repeat (3) @(negedge clk);
      total++;
      if ({gated_sig, cnt_clr_n, load, gate, busy, done, overflow} !== 7'b0100000) begin
         bad++;
         $display("FAIL reset_outputs: got %b want 0100000",
                  {gated_sig, cnt_clr_n, load, gate, busy, done, overflow});
      end
      @(posedge clk);
      #1 reset = 1'b1;
      repeat (4) @(negedge clk);
      total++;
      if (busy !== 1'b0) begin
         bad++;
         $display("FAIL reset_idle_busy: got %b want 0", busy);
      end
      $display("test_reset: reset values checked");
   endtask

   task automatic test_single();
      bit    ok;
      exp_t  e;
      meas_t m;
      exp_q.push_back('{ovf: 1'b0, fmin: 9, fmax: 11});
      pulse_start();
      wait_obs(1, 200, ok);
      total++;
      if (!ok) begin
         bad++;
         $display("FAIL single_timeout: got no done want done");
         return;
      end
      e = exp_q.pop_front();
      m = obs_q.pop_front();
      total++;
      if (m.clr_c !== CC) begin
         bad++;
         $display("FAIL single_clr: got %0d want %0d", m.clr_c, CC);
      end
      total++;
      if (m.gate_c !== GC) begin
         bad++;
         $display("FAIL single_gate: got %0d want %0d", m.gate_c, GC);
      end
      total++;
      if (m.load_c !== 1) begin
         bad++;
         $display("FAIL single_load: got %0d want 1", m.load_c);
      end
      total++;
      if (m.busy_c !== MEAS) begin
         bad++;
         $display("FAIL single_busy: got %0d want %0d", m.busy_c, MEAS);
      end
      total++;
      if (m.falls < e.fmin || m.falls > e.fmax) begin
         bad++;
         $display("FAIL single_falls: got %0d want %0d..%0d", m.falls, e.fmin, e.fmax);
      end
      total++;
      if (m.leak !== 0) begin
         bad++;
         $display("FAIL single_leak: got %0d want 0", m.leak);
      end
      total++;
      if (m.ovf_done !== e.ovf) begin
         bad++;
         $display("FAIL single_ovf: got %b want %b", m.ovf_done, e.ovf);
      end
      @(negedge clk);
      total++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         bad++;
         $display("FAIL single_idle: got busy=%b done=%b want 0 0", busy, done);
      end
      $display("test_single: clr=%0d gate=%0d load=%0d busy=%0d falls=%0d",
               m.clr_c, m.gate_c, m.load_c, m.busy_c, m.falls);
   endtask

   task automatic test_overflow();
      bit    ok;
      exp_t  e;
      meas_t m;
      exp_q.push_back('{ovf: 1'b1, fmin: 9, fmax: 11});
      pulse_start();
      wait_gate(20, ok);
      total++;
      if (!ok) begin
         bad++;
         $display("FAIL ovf_gate_timeout: got no gate want gate");
         return;
      end
      repeat (20) @(negedge clk);
      ovf_in = 1'b1;
      repeat (3) @(negedge clk);
      ovf_in = 1'b0;
      wait_obs(1, 100, ok);
      total++;
      if (!ok) begin
         bad++;
         $display("FAIL ovf_timeout: got no done want done");
         return;
      end
      e = exp_q.pop_front();
      m = obs_q.pop_front();
      total++;
      if (m.ovf_load !== e.ovf) begin
         bad++;
         $display("FAIL ovf_at_load: got %b want %b", m.ovf_load, e.ovf);
      end
      total++;
      if (m.ovf_done !== e.ovf) begin
         bad++;
         $display("FAIL ovf_at_done: got %b want %b", m.ovf_done, e.ovf);
      end
      repeat (5) @(negedge clk);
      total++;
      if (overflow !== 1'b1) begin
         bad++;
         $display("FAIL ovf_hold_idle: got %b want 1", overflow);
      end
      $display("test_overflow: overflow at load=%b done=%b", m.ovf_load, m.ovf_done);
   endtask

   task automatic test_stop();
      bit ok;
      int ld;
      int dn;
      ld = load_total;
      dn = done_total;
      pulse_start();
      wait_gate(20, ok);
      total++;
      if (!ok) begin
         bad++;
         $display("FAIL stop_gate_timeout: got no gate want gate");
         return;
      end
      repeat (10) @(negedge clk);
      stop = 1'b1;
      @(negedge clk);
      total++;
      if ({gate, gated_sig, cnt_clr_n, busy} !== 4'b0010) begin
         bad++;
         $display("FAIL stop_outputs: got gate,gs,clr_n,busy=%b want 0010",
                  {gate, gated_sig, cnt_clr_n, busy});
      end
      total++;
      if (overflow !== 1'b1) begin
         bad++;
         $display("FAIL stop_overflow: got %b want 1", overflow);
      end
      stop = 1'b0;
      repeat (60) @(negedge clk);
      total++;
      if (load_total !== ld || done_total !== dn) begin
         bad++;
         $display("FAIL stop_no_load: got loads=%0d dones=%0d want %0d %0d",
                  load_total, done_total, ld, dn);
      end
      total++;
      if (busy !== 1'b0) begin
         bad++;
         $display("FAIL stop_idle: got busy=%b want 0", busy);
      end
      $display("test_stop: aborted at gate cycle 10");
   endtask

   task automatic test_clean();
      bit    ok;
      exp_t  e;
      meas_t m;
      exp_q.push_back('{ovf: 1'b0, fmin: 9, fmax: 11});
      pulse_start();
      wait_obs(1, 200, ok);
      total++;
      if (!ok) begin
         bad++;
         $display("FAIL clean_timeout: got no done want done");
         return;
      end
      e = exp_q.pop_front();
      m = obs_q.pop_front();
      total++;
      if (m.ovf_load !== e.ovf) begin
         bad++;
         $display("FAIL clean_ovf: got %b want %b", m.ovf_load, e.ovf);
      end
      total++;
      if (m.falls < e.fmin || m.falls > e.fmax) begin
         bad++;
         $display("FAIL clean_falls: got %0d want %0d..%0d", m.falls, e.fmin, e.fmax);
      end
      $display("test_clean: overflow=%b falls=%0d", m.ovf_load, m.falls);
   endtask

   task automatic test_back_to_back();
      bit    ok;
      exp_t  e;
      meas_t m;
      int    prev_cyc;
      @(posedge clk);
      #1 cont = 1'b1;
      for (int k = 0; k < 3; k++) exp_q.push_back('{ovf: 1'b0, fmin: 9, fmax: 11});
      pulse_start();
      wait_obs(1, 200, ok);
      total++;
      if (!ok) begin
         bad++;
         $display("FAIL cont_timeout1: got no done want done");
         cont = 1'b0;
         return;
      end
      @(negedge clk);
      total++;
      if (cnt_clr_n !== 1'b0 || busy !== 1'b1) begin
         bad++;
         $display("FAIL cont_restart: got clr_n=%b busy=%b want 0 1", cnt_clr_n, busy);
      end
      wait_obs(2, 200, ok);
      #1 cont = 1'b0;
      wait_obs(3, 200, ok);
      total++;
      if (!ok) begin
         bad++;
         $display("FAIL cont_timeout3: got %0d records want 3", obs_q.size());
         return;
      end
      prev_cyc = 0;
      for (int k = 0; k < 3; k++) begin
         e = exp_q.pop_front();
         m = obs_q.pop_front();
         total++;
         if (m.busy_c !== MEAS || m.ovf_done !== e.ovf ||
             m.falls < e.fmin || m.falls > e.fmax) begin
            bad++;
            $display("FAIL cont_meas%0d: got busy=%0d ovf=%b falls=%0d want %0d %b %0d..%0d",
                     k, m.busy_c, m.ovf_done, m.falls, MEAS, e.ovf, e.fmin, e.fmax);
         end
         if (k > 0) begin
            total++;
            if (m.load_cyc - prev_cyc !== MEAS) begin
               bad++;
               $display("FAIL cont_spacing%0d: got %0d want %0d",
                        k, m.load_cyc - prev_cyc, MEAS);
            end
         end
         prev_cyc = m.load_cyc;
         $display("test_back_to_back: meas %0d load at cycle %0d falls=%0d",
                  k, m.load_cyc, m.falls);
      end
      @(negedge clk);
      total++;
      if (busy !== 1'b0) begin
         bad++;
         $display("FAIL cont_end_idle: got busy=%b want 0", busy);
      end
   endtask

   task automatic test_reset_mid_gate();
      bit ok;
      int ld;
      pulse_start();
      wait_gate(20, ok);
      total++;
      if (!ok) begin
         bad++;
         $display("FAIL rstmid_gate_timeout: got no gate want gate");
         return;
      end
      repeat (5) @(negedge clk);
      ld = load_total;
      @(posedge clk);
      #3 reset = 1'b0;
      #1;
      total++;
      if ({gated_sig, cnt_clr_n, load, gate, busy, done, overflow} !== 7'b0100000) begin
         bad++;
         $display("FAIL rstmid_outputs: got %b want 0100000",
                  {gated_sig, cnt_clr_n, load, gate, busy, done, overflow});
      end
      repeat (3) @(posedge clk);
      #1 reset = 1'b1;
      repeat (60) @(negedge clk);
      total++;
      if (load_total !== ld || busy !== 1'b0 || obs_q.size() !== 0) begin
         bad++;
         $display("FAIL rstmid_no_load: got loads=%0d busy=%b recs=%0d want %0d 0 0",
                  load_total, busy, obs_q.size(), ld);
      end
      $display("test_reset_mid_gate: measurement discarded");
   endtask

   task automatic test_stop_start_idle();
      @(posedge clk);
      #1 begin
         stop  = 1'b1;
         start = 1'b1;
      end
      @(posedge clk);
      #1 begin
         stop  = 1'b0;
         start = 1'b0;
      end
      repeat (3) @(negedge clk);
      total++;
      if (busy !== 1'b0 || cnt_clr_n !== 1'b1) begin
         bad++;
         $display("FAIL stop_start_idle: got busy=%b clr_n=%b want 0 1", busy, cnt_clr_n);
      end
      $display("test_stop_start_idle: stayed idle");
   endtask

   initial begin
      test_reset();
      test_single();
      test_overflow();
      test_stop();
      test_clean();
      test_back_to_back();
      test_reset_mid_gate();
      test_stop_start_idle();
      total++;
      if (excl_err !== 0) begin
         bad++;
         $display("FAIL exclusive_outputs: got %0d overlaps want 0", excl_err);
      end
      total++;
      if (exp_q.size() !== 0) begin
         bad++;
         $display("FAIL scoreboard_left: got %0d pending want 0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Safety net so the run always terminates.
   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish want finish");
      $fatal(1, "timeout");
   end

endmodule
